pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register that replaces the fixed, enable-gated inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries a packed control bundle and a packed datapath bundle per stage.
- Uses a valid/ready handshake with a 2-entry skid buffer, so the block sustains full throughput and can stall without a combinational ready path.
- Adds synchronous flush for branch/jump squash and synchronous active-low reset.

Parameters:
- CTRL_W, 16, width of packed control bundle (regWrite, memRead, memWrite, MemToReg, Branch, Jump, ALUSrc, ALUControl, ...)
- DATA_W, 165, width of packed datapath bundle (IR, PC, B, Result, regDest, ...)
- FLUSH_ZERO, 1, 1 = flush also clears stored bundles to 0 (canonical NOP); 0 = only valid bits cleared

Ports:
- clk  in  1  stage clock, all state on rising edge
- rst_n  in  1  synchronous reset, active low
- in_valid  in  1  upstream stage presents a bundle
- in_ready  out  1  block can accept; registered, no combinational path from out_ready
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream datapath bundle
- out_valid  out  1  downstream bundle valid
- out_ready  in  1  downstream accepts (0 = hazard stall)
- out_ctrl  out  CTRL_W  registered control bundle
- out_data  out  DATA_W  registered datapath bundle
- flush  in  1  squash all held entries this cycle
- occupancy  out  2  number of held entries, 0..2

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_ctrl=0, out_data=0, skid entry invalid and zeroed.
  - occupancy=0; in_ready=1 from the first cycle after reset.
  - Reset overrides flush and any handshake in the same cycle.
- Handshakes:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency is 1 cycle from input transfer to out_valid when the block is empty.
- States, encoded by occupancy:
  - EMPTY(0): out_valid=0, in_ready=1. On input transfer, load the main register; go to ONE.
  - ONE(1): out_valid=1, in_ready=1.
    - Input and output transfer together: main loads new bundle; stay ONE.
    - Output only: go to EMPTY.
    - Input only (stall): the new bundle goes to the skid register; go to FULL; in_ready=0 next cycle.
  - FULL(2): in_ready=0, out_valid=1. On output transfer, move skid to main; go to ONE.
- Ordering: strict FIFO. No bundle is duplicated or dropped except by flush.
- Flush (rst_n=1, flush=1):
  - Go to EMPTY next cycle; out_valid=0, in_ready=1.
  - An input presented in the flush cycle is discarded, even if in_ready=1.
  - An output transfer in the flush cycle still counts as consumed downstream.
  - FLUSH_ZERO=1: main and skid bundles are cleared to 0. FLUSH_ZERO=0: bundles hold their last value.
- out_ctrl and out_data hold their value while out_valid=0, except after reset or a zeroing flush.
- in_valid=0 with out_ready=0 in EMPTY: no change.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN
- Defined, the block adds:
  - stall_cnt (out, 32): increments each cycle with out_valid && !out_ready.
  - flush_cnt (out, 16): increments on each flush cycle that discards at least one valid entry or input.
  - Both counters reset to 0 on rst_n=0 and wrap modulo 2^N.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - Stage control-bundle struct and its width constant.
  - Per-stage data-bundle widths (IFID_W, IDEX_W, EXMEM_W, MEMWB_W).
  - NOP bundle constant.
- Natural sub-module: pipe_skid_slot, a single entry with valid bit, load enable and synchronous clear. Instantiate it twice (main, skid).

Test Plan:
- Reset, then in_valid=1, in_data=0x...1234, out_ready=1 -> out_valid=1 one cycle later with out_data=0x...1234; occupancy=1.
- Stream 8 bundles (values 1..8) with out_ready=1 throughout -> 8 consecutive outputs 1..8, in_ready stays 1, no gaps.
- Send A, B with out_ready=0 -> occupancy=2 and in_ready=0 after B. Raise out_ready -> A then B on consecutive cycles; in_ready=1 one cycle after A leaves.
- In FULL state assert flush=1 with in_valid=1, C presented -> next cycle out_valid=0, occupancy=0, C never appears. With FLUSH_ZERO=1, out_data=0.
- Assert rst_n=0 together with flush=1 and in_valid=1 while in ONE -> all outputs 0, in_ready=1 on the first cycle with rst_n=1.
- With PIPE_STAGE_PERF_EN defined, hold out_ready=0 for 5 cycles while out_valid=1, then flush a full block -> stall_cnt=5, flush_cnt=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline package: control bundle, per-stage widths, NOP and
// skid-register occupancy states.
package pipe_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic [3:0] alu_ctrl;
    logic [4:0] rsvd;
  } ctrl_t;

  localparam int CTRL_BUNDLE_W = $bits(ctrl_t);

  localparam int IFID_W  = 64;
  localparam int IDEX_W  = 165;
  localparam int EXMEM_W = 107;
  localparam int MEMWB_W = 70;

  localparam ctrl_t NOP_CTRL = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Stage handshake bundle: upstream, downstream, flush and occupancy.
import pipe_pkg::*;

interface pipe_stage_reg_if #(
  parameter int CTRL_W = CTRL_BUNDLE_W,
  parameter int DATA_W = IDEX_W
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic [1:0]        occupancy;

  modport master (
    output in_valid, in_ctrl, in_data,
    output out_ready, flush,
    input  in_ready, out_valid,
    input  out_ctrl, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_ctrl, in_data,
    input  out_ready, flush,
    output in_ready, out_valid,
    output out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_slot.sv
// One held bundle: valid bit, load, drop (valid only) and flush clear.
module pipe_skid_slot #(
  parameter int W        = 8,
  parameter bit CLR_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         drop,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);
  logic         v_d, v_q;
  logic [W-1:0] q_d, q_q;

  always_comb begin
    v_d = v_q;
    q_d = q_q;
    if (clr) begin
      v_d = 1'b0;
      if (CLR_ZERO) q_d = '0;
    end else if (ld) begin
      v_d = 1'b1;
      q_d = d;
    end else if (drop) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      q_q <= '0;
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

  assign valid = v_q;
  assign q     = q_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register with 2-entry skid buffer and flush.
// PIPE_STAGE_PERF_EN adds stall_cnt/flush_cnt performance counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W     = CTRL_BUNDLE_W,
  parameter int DATA_W     = IDEX_W,
  parameter bit FLUSH_ZERO = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  pipe_stage_reg_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]    stall_cnt,
  output logic [15:0]    flush_cnt
`endif
);
  localparam int W = CTRL_W + DATA_W;

  occ_e state_q, state_d;

  logic         in_xfer, out_xfer;
  logic         main_ld, main_drop, main_from_skid;
  logic         skid_ld, skid_drop;
  logic         main_v, skid_v;
  logic [W-1:0] in_b, main_d, main_q, skid_q;

  assign in_b     = {bus.in_ctrl, bus.in_data};
  assign in_xfer  = bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_drop      = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_drop      = 1'b0;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_ld = 1'b1;
          end else if (out_xfer) begin
            main_drop = 1'b1;
            state_d   = ST_EMPTY;
          end else if (in_xfer) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_drop      = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  assign main_d = main_from_skid ? skid_q : in_b;

  pipe_skid_slot #(.W(W), .CLR_ZERO(FLUSH_ZERO)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (main_ld),
    .drop  (main_drop),
    .clr   (bus.flush),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  pipe_skid_slot #(.W(W), .CLR_ZERO(FLUSH_ZERO)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (skid_ld),
    .drop  (skid_drop),
    .clr   (bus.flush),
    .d     (in_b),
    .valid (skid_v),
    .q     (skid_q)
  );

  // in_ready comes straight from the skid flop, never from out_ready
  assign bus.in_ready  = !skid_v;
  assign bus.out_valid = main_v;
  assign {bus.out_ctrl, bus.out_data} = main_q;
  assign bus.occupancy = state_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_d, stall_q;
  logic [15:0] flcnt_d, flcnt_q;
  logic        discard;

  assign discard = bus.flush &&
    (bus.in_valid || state_q == ST_FULL ||
     (state_q == ST_ONE && !bus.out_ready));

  always_comb begin
    stall_d = stall_q;
    flcnt_d = flcnt_q;
    if (bus.out_valid && !bus.out_ready)
      stall_d = stall_q + 32'd1;
    if (discard)
      flcnt_d = flcnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flcnt_q <= '0;
    end else begin
      stall_q <= stall_d;
      flcnt_q <= flcnt_d;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flcnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector table for handshake state plus
// a scoreboard queue checking every bundle leaving the stage.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  localparam int CW = 16;
  localparam int DW = 165;
  localparam int BW = CW + DW;

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] d;
    logic        ov;
    logic        ir;
    logic [1:0]  occ;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;
`endif

  pipe_stage_reg #(
    .CTRL_W(CW), .DATA_W(DW), .FLUSH_ZERO(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] sb[$];
  vec_t tbl[$];

  function automatic logic [DW-1:0] mk_data(logic [31:0] d);
    return {5'h15, d, ~d, d, ~d, d};
  endfunction

  function automatic logic [CW-1:0] mk_ctrl(logic [31:0] d);
    return d[15:0] ^ 16'hA5A5;
  endfunction

  task automatic chk(string nm, logic [BW-1:0] act,
                     logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic iv, logic ordy, logic fl,
                       logic [31:0] d);
    bus.in_valid  = iv;
    bus.out_ready = ordy;
    bus.flush     = fl;
    bus.in_ctrl   = mk_ctrl(d);
    bus.in_data   = mk_data(d);
  endtask

  // Sampled mid-cycle: these are the transfers the next edge performs
  task automatic sb_sample();
    logic [BW-1:0] e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_bundle", {bus.out_ctrl, bus.out_data}, e);
        end
      end
      if (bus.flush) sb.delete();
      else if (bus.in_valid && bus.in_ready)
        sb.push_back({bus.in_ctrl, bus.in_data});
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    sb_sample();
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic iv, logic ordy, logic fl,
                     logic [31:0] d, logic ov, logic ir,
                     logic [1:0] occ, logic zero);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d;
    v.ov = ov; v.ir = ir; v.occ = occ; v.zero = zero;
    tbl.push_back(v);
  endtask

  task automatic chk_state(string nm, logic ov, logic ir,
                           logic [1:0] occ);
    chk({nm, "_out_valid"}, BW'(bus.out_valid), BW'(ov));
    chk({nm, "_in_ready"}, BW'(bus.in_ready), BW'(ir));
    chk({nm, "_occupancy"}, BW'(bus.occupancy), BW'(occ));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    // single transfer, 1-cycle latency
    add(1, 1, 0, 32'h1234, 1, 1, 1, 0);
    add(0, 1, 0, 0,        0, 1, 0, 0);
    // 8-bundle stream at full rate
    for (int k = 1; k <= 8; k++)
      add(1, 1, 0, k, 1, 1, 1, 0);
    add(0, 1, 0, 0, 0, 1, 0, 0);
    // A, B into a stalled stage, then drain
    add(1, 0, 0, 32'hA, 1, 1, 1, 0);
    add(1, 0, 0, 32'hB, 1, 0, 2, 0);
    add(0, 0, 0, 0,     1, 0, 2, 0);
    add(0, 1, 0, 0,     1, 1, 1, 0);
    add(0, 1, 0, 0,     0, 1, 0, 0);
    // flush in FULL with C presented
    add(1, 0, 0, 32'hD, 1, 1, 1, 0);
    add(1, 0, 0, 32'hE, 1, 0, 2, 0);
    add(1, 0, 1, 32'hC, 0, 1, 0, 1);
    add(0, 1, 0, 0,     0, 1, 0, 1);
    // idle EMPTY with stall: no change
    add(0, 0, 0, 0,     0, 1, 0, 1);
    // flush in ONE while downstream consumes
    add(1, 0, 0, 32'hF, 1, 1, 1, 0);
    add(0, 1, 1, 0,     0, 1, 0, 1);
    // FULL drains while input waits on in_ready
    add(1, 0, 0, 32'h61, 1, 1, 1, 0);
    add(1, 0, 0, 32'h62, 1, 0, 2, 0);
    add(1, 1, 0, 32'h63, 1, 1, 1, 0);
    add(1, 1, 0, 32'h63, 1, 1, 1, 0);
    add(0, 1, 0, 0,      0, 1, 0, 0);

    do_reset();
    chk_state("reset", 0, 1, 0);
    chk("reset_out_data", BW'(bus.out_data), '0);
    chk("reset_out_ctrl", BW'(bus.out_ctrl), '0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].d);
      cycle();
      chk_state($sformatf("row%0d", i),
                tbl[i].ov, tbl[i].ir, tbl[i].occ);
      if (tbl[i].zero)
        chk($sformatf("row%0d_zero", i),
            {bus.out_ctrl, bus.out_data}, '0);
    end

    // reset wins over flush and a pending input
    drive(1, 0, 0, 32'h77);
    cycle();
    chk_state("pre_rst", 1, 1, 1);
    rst_n = 1'b0;
    drive(1, 0, 1, 32'h78);
    cycle();
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    chk_state("rst_flush", 0, 1, 0);
    chk("rst_flush_bundle", {bus.out_ctrl, bus.out_data}, '0);

`ifdef PIPE_STAGE_PERF_EN
    do_reset();
    chk("perf_stall_rst", BW'(stall_cnt), '0);
    chk("perf_flush_rst", BW'(flush_cnt), '0);
    drive(1, 0, 0, 32'h91);
    cycle();
    drive(1, 0, 0, 32'h92);
    cycle();
    chk_state("perf_full", 1, 0, 2);
    drive(0, 0, 0, 0);
    repeat (3) cycle();
    drive(0, 0, 1, 0);
    cycle();
    drive(0, 0, 0, 0);
    cycle();
    chk("perf_stall", BW'(stall_cnt), BW'(32'd5));
    chk("perf_flush", BW'(flush_cnt), BW'(16'd1));
`endif

    chk("sb_drain", BW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
